// File: rtl/alu2_wb.sv
// rtl/alu2_wb.sv - alu2 writeback stage: 2-entry in-order retire buffer, flag register, optional forwarding (ALU2_WB_FWD_EN)
module alu2_wb #(
    parameter int WIDTH = 32,
    parameter int RIDX  = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_res,
    input  logic [7:0]       in_fo,
    input  logic             in_wb_en,
    input  logic             in_flag_en,
    input  logic [RIDX-1:0]  in_dst,
    input  logic             rf_stall,
    output logic             rf_we,
    output logic [RIDX-1:0]  rf_waddr,
    output logic [WIDTH-1:0] rf_wdata,
    output logic [7:0]       flags,
    input  logic [RIDX-1:0]  q_d_idx,
    input  logic [RIDX-1:0]  q_b_idx,
    output logic             fwd_d_hit,
    output logic [WIDTH-1:0] fwd_d_data,
    output logic             fwd_b_hit,
    output logic [WIDTH-1:0] fwd_b_data,
    output logic             busy
);

    logic [1:0]       r_count;
    logic             r_head;
    logic             r_tail;
    logic [1:0]       r_valid;
    logic [1:0]       r_wb;
    logic [1:0]       r_fe;
    logic [WIDTH-1:0] r_res [2];
    logic [7:0]       r_fo  [2];
    logic [RIDX-1:0]  r_dst [2];
    logic [7:0]       r_flags;
    logic [RIDX-1:0]  r_last_waddr;
    logic [WIDTH-1:0] r_last_wdata;

    logic w_full;
    logic w_accept;
    logic w_head_wr;
    logic w_retire;

    assign w_full    = (r_count == 2'd2);
    assign w_accept  = in_valid && !w_full;
    // A head without a register write never waits on the register file.
    assign w_head_wr = r_valid[r_head] && r_wb[r_head];
    assign w_retire  = r_valid[r_head] && (!r_wb[r_head] || !rf_stall);

    assign in_ready = !w_full;
    assign busy     = (r_count != 2'd0);
    assign rf_we    = w_head_wr;
    // Address/data keep the last written values whenever no write is presented.
    assign rf_waddr = w_head_wr ? r_dst[r_head] : r_last_waddr;
    assign rf_wdata = w_head_wr ? r_res[r_head] : r_last_wdata;

    // Buffer storage, pointers, occupancy and the committed flag register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_count      <= 2'd0;
            r_head       <= 1'b0;
            r_tail       <= 1'b0;
            r_valid      <= 2'b00;
            r_wb         <= 2'b00;
            r_fe         <= 2'b00;
            r_flags      <= 8'h00;
            r_last_waddr <= '0;
            r_last_wdata <= '0;
            for (int i = 0; i < 2; i++) begin
                r_res[i] <= '0;
                r_fo[i]  <= 8'h00;
                r_dst[i] <= '0;
            end
        end else begin
            if (w_accept) begin
                r_res[r_tail]   <= in_res;
                r_fo[r_tail]    <= in_fo;
                r_dst[r_tail]   <= in_dst;
                r_wb[r_tail]    <= in_wb_en;
                r_fe[r_tail]    <= in_flag_en;
                r_valid[r_tail] <= 1'b1;
                r_tail          <= ~r_tail;
            end
            // Accept and retire never touch the same slot: that would need count 0 or 2.
            if (w_retire) begin
                r_valid[r_head] <= 1'b0;
                r_head          <= ~r_head;
                if (r_fe[r_head]) begin
                    r_flags <= r_fo[r_head];
                end
                if (r_wb[r_head]) begin
                    r_last_waddr <= r_dst[r_head];
                    r_last_wdata <= r_res[r_head];
                end
            end
            case ({w_accept, w_retire})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

`ifdef ALU2_WB_FWD_EN
    logic w_old;
    logic w_new;

    // Slot at tail is the older entry (only valid when full); the other slot is the newest.
    assign w_old = r_tail;
    assign w_new = ~r_tail;

    // Newest pending value wins: evaluate the older slot first, then let the newer override.
    always_comb begin
        fwd_d_hit  = 1'b0;
        fwd_d_data = '0;
        fwd_b_hit  = 1'b0;
        fwd_b_data = '0;
        flags      = r_flags;
        if (r_valid[w_old] && r_wb[w_old] && (r_dst[w_old] == q_d_idx)) begin
            fwd_d_hit  = 1'b1;
            fwd_d_data = r_res[w_old];
        end
        if (r_valid[w_old] && r_wb[w_old] && (r_dst[w_old] == q_b_idx)) begin
            fwd_b_hit  = 1'b1;
            fwd_b_data = r_res[w_old];
        end
        if (r_valid[w_old] && r_fe[w_old]) begin
            flags = r_fo[w_old];
        end
        if (r_valid[w_new] && r_wb[w_new] && (r_dst[w_new] == q_d_idx)) begin
            fwd_d_hit  = 1'b1;
            fwd_d_data = r_res[w_new];
        end
        if (r_valid[w_new] && r_wb[w_new] && (r_dst[w_new] == q_b_idx)) begin
            fwd_b_hit  = 1'b1;
            fwd_b_data = r_res[w_new];
        end
        if (r_valid[w_new] && r_fe[w_new]) begin
            flags = r_fo[w_new];
        end
    end
`else
    // Without forwarding the upstream stalls on dependencies, so only committed state is shown.
    always_comb begin
        fwd_d_hit  = 1'b0;
        fwd_d_data = '0;
        fwd_b_hit  = 1'b0;
        fwd_b_data = '0;
        flags      = r_flags;
    end
`endif

endmodule
